// File: rtl/ldl_cdc_pkg.sv
// Purpose : shared types and constants for the toggle-handshake CDC receiver.
// Latency : n/a (types and constants only).
// Backpressure: n/a.
// Contents: cdc_state_t (receiver FSM state), CDC_LEVEL_MIN (shallowest
//           synchroniser that still gives a metastability settling stage).
package ldl_cdc_pkg;

   // Two flops is the shallowest chain that still gives the first stage a
   // full cycle to resolve before the value is used.
   localparam int CDC_LEVEL_MIN = 2;

   typedef enum logic {
      CDC_IDLE  = 1'b0,
      CDC_VALID = 1'b1
   } cdc_state_t;

endpackage

// File: rtl/LDL_cdc_buff_v1.sv
// Purpose : LEVEL-deep flop chain synchronising an asynchronous bus into i_clk.
// Latency : LEVEL enabled i_clk edges from i_d to o_q.
// Backpressure: i_en = 0 freezes every stage, so nothing advances or is lost.
// Ports   : i_clk   destination clock
//           i_rst   synchronous active-high reset, clears every stage
//           i_en    clock enable for the whole chain
//           i_d     asynchronous input (only WIDTH = 1 or gray-coded buses)
//           o_q     synchronised output, last stage of the chain
module LDL_cdc_buff_v1 #(
   parameter int WIDTH = 1,
   parameter int LEVEL = 2
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_en,
   input  logic [WIDTH-1:0] i_d,
   output logic [WIDTH-1:0] o_q
);

   logic [WIDTH-1:0] r_stage [LEVEL];

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         for (int i = 0; i < LEVEL; i++) begin
            r_stage[i] <= '0;
         end
      end else if (i_en) begin
         r_stage[0] <= i_d;
         for (int i = 1; i < LEVEL; i++) begin
            r_stage[i] <= r_stage[i-1];
         end
      end
   end

   assign o_q = r_stage[LEVEL-1];

endmodule

// File: rtl/ldl_cdc_hsk_rx_v1.sv
// Purpose : destination side of a two-phase req/ack CDC; captures the source
//           word on each request toggle and offers it on a valid/ready port.
// Latency : req_async toggle before edge k -> dout_valid high after edge k+LEVEL.
// Backpressure: the word is held in VALID until dout_ready; ack_out only
//           toggles on consumption, so the source cannot send the next word.
// Ports   : clk/rst      destination clock, synchronous active-high reset
//           en           0 freezes the req synchroniser and blocks captures
//           req_async    source request toggle
//           din_async    source data, stable while a request is outstanding
//           ack_out      acknowledge toggle back to the source (registered)
//           dout/dout_valid/dout_ready  downstream valid/ready interface
//           xfer_cnt     completed transfers, wraps silently
//           err          sticky: source toggled again before being acked
module ldl_cdc_hsk_rx_v1 #(
   parameter int WIDTH = 8,
   parameter int LEVEL = 2,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             req_async,
   input  logic [WIDTH-1:0] din_async,
   output logic             ack_out,
   output logic [WIDTH-1:0] dout,
   output logic             dout_valid,
   input  logic             dout_ready,
   output logic [CNT_W-1:0] xfer_cnt,
   output logic             err
);

   import ldl_cdc_pkg::*;

   if (LEVEL < CDC_LEVEL_MIN) begin : g_level_chk
      $error("ldl_cdc_hsk_rx_v1: LEVEL must be at least CDC_LEVEL_MIN");
   end
   if (WIDTH < 1) begin : g_width_chk
      $error("ldl_cdc_hsk_rx_v1: WIDTH must be at least 1");
   end

   logic             w_req_sync;
   logic             w_new_req;
   logic             w_capture;
   logic             w_handshake;
   logic             w_proto_err;
   cdc_state_t       w_state_nxt;

   cdc_state_t       r_state;
   logic             r_req_seen;
   logic             r_ack;
   logic             r_valid;
   logic             r_err;
   logic [WIDTH-1:0] r_dout;
   logic [CNT_W-1:0] r_cnt;

   LDL_cdc_buff_v1 #(
      .WIDTH (1),
      .LEVEL (LEVEL)
   ) u_req_sync (
      .i_clk (clk),
      .i_rst (rst),
      .i_en  (en),
      .i_d   (req_async),
      .o_q   (w_req_sync)
   );

   // Two-phase protocol: any difference between the synchronised request
   // and the last phase we acted on is one new request.
   assign w_new_req = w_req_sync ^ r_req_seen;

   always_comb begin
      w_state_nxt = r_state;
      w_capture   = 1'b0;
      w_handshake = 1'b0;
      w_proto_err = 1'b0;
      case (r_state)
         CDC_IDLE: begin
            if (en && w_new_req) begin
               w_capture   = 1'b1;
               w_state_nxt = CDC_VALID;
            end
         end
         CDC_VALID: begin
            // A toggle here means the source did not wait for our ack.
            w_proto_err = w_new_req;
            if (dout_ready) begin
               w_handshake = 1'b1;
               w_state_nxt = CDC_IDLE;
            end
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= CDC_IDLE;
         r_req_seen <= 1'b0;
         r_ack      <= 1'b0;
         r_valid    <= 1'b0;
         r_err      <= 1'b0;
         r_dout     <= '0;
         r_cnt      <= '0;
      end else begin
         r_state <= w_state_nxt;
         // The offending toggle is absorbed into req_seen so it is neither
         // captured now nor replayed as a fresh request once we reach IDLE.
         if (w_capture || w_proto_err) begin
            r_req_seen <= w_req_sync;
         end
         if (w_capture) begin
            r_dout  <= din_async;
            r_valid <= 1'b1;
         end
         if (w_handshake) begin
            r_valid <= 1'b0;
            r_ack   <= ~r_ack;
            r_cnt   <= r_cnt + CNT_W'(1);
         end
         if (w_proto_err) begin
            r_err <= 1'b1;
         end
      end
   end

   assign ack_out    = r_ack;
   assign dout       = r_dout;
   assign dout_valid = r_valid;
   assign xfer_cnt   = r_cnt;
   assign err        = r_err;

endmodule

// File: tb/tb_ldl_cdc_hsk_rx_v1.sv
// Purpose : directed self-checking bench for ldl_cdc_hsk_rx_v1.
// Latency : inputs change 1 time unit after a rising edge, outputs are read
//           1 time unit after the following edge.
// Backpressure: dout_ready is driven directly per scenario.
module tb_ldl_cdc_hsk_rx_v1;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        en = 1'b1;
   logic        req = 1'b0;
   logic [7:0]  din = 8'h00;
   logic        ready = 1'b0;

   logic        ack;
   logic [7:0]  dout;
   logic        valid;
   logic [15:0] cnt;
   logic        err;

   logic        ack2;
   logic [7:0]  dout2;
   logic        valid2;
   logic [1:0]  cnt2;
   logic        err2;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   ldl_cdc_hsk_rx_v1 #(.WIDTH(8), .LEVEL(2), .CNT_W(16)) u_dut (
      .clk        (clk),
      .rst        (rst),
      .en         (en),
      .req_async  (req),
      .din_async  (din),
      .ack_out    (ack),
      .dout       (dout),
      .dout_valid (valid),
      .dout_ready (ready),
      .xfer_cnt   (cnt),
      .err        (err)
   );

   // Narrow-counter copy sharing the same stimulus, used for the wrap check.
   ldl_cdc_hsk_rx_v1 #(.WIDTH(8), .LEVEL(2), .CNT_W(2)) u_dut_w2 (
      .clk        (clk),
      .rst        (rst),
      .en         (en),
      .req_async  (req),
      .din_async  (din),
      .ack_out    (ack2),
      .dout       (dout2),
      .dout_valid (valid2),
      .dout_ready (ready),
      .xfer_cnt   (cnt2),
      .err        (err2)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic tickn(input int n);
      repeat (n) tick();
   endtask

   task automatic do_reset();
      rst   = 1'b1;
      req   = 1'b0;
      en    = 1'b1;
      ready = 1'b0;
      din   = 8'h00;
      tickn(2);
      rst   = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1; req = 1'b1; din = 8'h5A; en = 1'b1; ready = 1'b0;
      tickn(3);
      n_cmp++; if (valid !== 1'b0) begin n_bad++; $display("FAIL rst_valid: got %b exp 0", valid); end
      n_cmp++; if (dout !== 8'h00) begin n_bad++; $display("FAIL rst_dout: got %h exp 00", dout); end
      n_cmp++; if (ack !== 1'b0) begin n_bad++; $display("FAIL rst_ack: got %b exp 0", ack); end
      n_cmp++; if (cnt !== 16'd0) begin n_bad++; $display("FAIL rst_cnt: got %0d exp 0", cnt); end
      n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL rst_err: got %b exp 0", err); end
      rst = 1'b0;
      tick();
      n_cmp++; if (valid !== 1'b0 || dout !== 8'h00) begin n_bad++; $display("FAIL rel_edge1: got v=%b d=%h exp v=0 d=00", valid, dout); end
      tick();
      n_cmp++; if (valid !== 1'b0) begin n_bad++; $display("FAIL rel_edge2: got v=%b exp 0", valid); end
      tick();
      n_cmp++; if (valid !== 1'b1 || dout !== 8'h5A) begin n_bad++; $display("FAIL rel_capture: got v=%b d=%h exp v=1 d=5a", valid, dout); end
      ready = 1'b1;
      tick();
      n_cmp++; if (valid !== 1'b0 || ack !== 1'b1 || cnt !== 16'd1) begin n_bad++; $display("FAIL rel_hsk: got v=%b a=%b c=%0d exp v=0 a=1 c=1", valid, ack, cnt); end
      tickn(4);
      n_cmp++; if (valid !== 1'b0 || cnt !== 16'd1) begin n_bad++; $display("FAIL rel_once: got v=%b c=%0d exp v=0 c=1", valid, cnt); end
   endtask

   task automatic test_latency();
      do_reset();
      ready = 1'b1; din = 8'hA5; req = ~req;
      tick();
      n_cmp++; if (valid !== 1'b0) begin n_bad++; $display("FAIL lat_k: got %b exp 0", valid); end
      tick();
      n_cmp++; if (valid !== 1'b0) begin n_bad++; $display("FAIL lat_k1: got %b exp 0", valid); end
      tick();
      n_cmp++; if (valid !== 1'b1 || dout !== 8'hA5) begin n_bad++; $display("FAIL lat_k2: got v=%b d=%h exp v=1 d=a5", valid, dout); end
      tick();
      n_cmp++; if (valid !== 1'b0 || ack !== 1'b1 || cnt !== 16'd1) begin n_bad++; $display("FAIL lat_hsk: got v=%b a=%b c=%0d exp v=0 a=1 c=1", valid, ack, cnt); end
   endtask

   task automatic test_hold_back_to_back();
      logic [7:0] pat [4];
      pat = '{8'h55, 8'hAA, 8'h55, 8'hAA};
      do_reset();
      ready = 1'b0; din = 8'h3C; req = ~req;
      tickn(3);
      n_cmp++; if (valid !== 1'b1 || dout !== 8'h3C) begin n_bad++; $display("FAIL hold_cap: got v=%b d=%h exp v=1 d=3c", valid, dout); end
      din = 8'hC3;
      for (int i = 0; i < 10; i++) begin
         tick();
         n_cmp++; if (valid !== 1'b1 || dout !== 8'h3C || ack !== 1'b0) begin n_bad++; $display("FAIL hold_cyc%0d: got v=%b d=%h a=%b exp v=1 d=3c a=0", i, valid, dout, ack); end
      end
      ready = 1'b1;
      tick();
      n_cmp++; if (valid !== 1'b0 || ack !== 1'b1 || cnt !== 16'd1) begin n_bad++; $display("FAIL hold_hsk: got v=%b a=%b c=%0d exp v=0 a=1 c=1", valid, ack, cnt); end
      for (int i = 0; i < 4; i++) begin
         din = pat[i]; req = ~req;
         tickn(3);
         n_cmp++; if (valid !== 1'b1 || dout !== pat[i]) begin n_bad++; $display("FAIL b2b_cap%0d: got v=%b d=%h exp v=1 d=%h", i, valid, dout, pat[i]); end
         tick();
         n_cmp++; if (valid !== 1'b0 || cnt !== 16'(i + 2)) begin n_bad++; $display("FAIL b2b_hsk%0d: got v=%b c=%0d exp v=0 c=%0d", i, valid, cnt, i + 2); end
      end
      n_cmp++; if (cnt !== 16'd5 || err !== 1'b0 || ack !== 1'b1) begin n_bad++; $display("FAIL b2b_end: got c=%0d e=%b a=%b exp c=5 e=0 a=1", cnt, err, ack); end
   endtask

   task automatic test_err();
      do_reset();
      ready = 1'b0; din = 8'h11; req = ~req;
      tickn(3);
      n_cmp++; if (valid !== 1'b1 || dout !== 8'h11 || err !== 1'b0) begin n_bad++; $display("FAIL err_cap: got v=%b d=%h e=%b exp v=1 d=11 e=0", valid, dout, err); end
      din = 8'h22; req = ~req;
      tickn(2);
      n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL err_early: got %b exp 0", err); end
      tick();
      n_cmp++; if (err !== 1'b1 || valid !== 1'b1 || dout !== 8'h11) begin n_bad++; $display("FAIL err_set: got e=%b v=%b d=%h exp e=1 v=1 d=11", err, valid, dout); end
      ready = 1'b1;
      tick();
      n_cmp++; if (valid !== 1'b0 || ack !== 1'b1 || cnt !== 16'd1 || err !== 1'b1) begin n_bad++; $display("FAIL err_hsk: got v=%b a=%b c=%0d e=%b exp v=0 a=1 c=1 e=1", valid, ack, cnt, err); end
      tickn(5);
      n_cmp++; if (valid !== 1'b0 || dout !== 8'h11 || cnt !== 16'd1 || err !== 1'b1) begin n_bad++; $display("FAIL err_nocap: got v=%b d=%h c=%0d e=%b exp v=0 d=11 c=1 e=1", valid, dout, cnt, err); end
   endtask

   task automatic test_simultaneous();
      do_reset();
      ready = 1'b0; din = 8'h44; req = ~req;
      tickn(3);
      n_cmp++; if (valid !== 1'b1 || dout !== 8'h44) begin n_bad++; $display("FAIL sim_cap: got v=%b d=%h exp v=1 d=44", valid, dout); end
      req = ~req;
      tickn(2);
      ready = 1'b1;
      tick();
      n_cmp++; if (valid !== 1'b0 || ack !== 1'b1 || cnt !== 16'd1 || err !== 1'b1) begin n_bad++; $display("FAIL sim_hsk: got v=%b a=%b c=%0d e=%b exp v=0 a=1 c=1 e=1", valid, ack, cnt, err); end
      tickn(4);
      n_cmp++; if (valid !== 1'b0 || cnt !== 16'd1) begin n_bad++; $display("FAIL sim_after: got v=%b c=%0d exp v=0 c=1", valid, cnt); end
   endtask

   task automatic test_enable();
      do_reset();
      ready = 1'b1; en = 1'b0; din = 8'h77; req = ~req;
      tickn(5);
      n_cmp++; if (valid !== 1'b0 || cnt !== 16'd0) begin n_bad++; $display("FAIL en_block: got v=%b c=%0d exp v=0 c=0", valid, cnt); end
      en = 1'b1;
      tick();
      n_cmp++; if (valid !== 1'b0) begin n_bad++; $display("FAIL en_e1: got %b exp 0", valid); end
      tick();
      n_cmp++; if (valid !== 1'b0) begin n_bad++; $display("FAIL en_e2: got %b exp 0", valid); end
      tick();
      n_cmp++; if (valid !== 1'b1 || dout !== 8'h77) begin n_bad++; $display("FAIL en_e3: got v=%b d=%h exp v=1 d=77", valid, dout); end
      tick();
      n_cmp++; if (valid !== 1'b0 || cnt !== 16'd1 || ack !== 1'b1) begin n_bad++; $display("FAIL en_hsk: got v=%b c=%0d a=%b exp v=0 c=1 a=1", valid, cnt, ack); end
      ready = 1'b0; din = 8'h88; req = ~req;
      tickn(3);
      n_cmp++; if (valid !== 1'b1 || dout !== 8'h88) begin n_bad++; $display("FAIL en_cap2: got v=%b d=%h exp v=1 d=88", valid, dout); end
      en = 1'b0; ready = 1'b1;
      tick();
      n_cmp++; if (valid !== 1'b0 || cnt !== 16'd2 || ack !== 1'b0) begin n_bad++; $display("FAIL en_off_hsk: got v=%b c=%0d a=%b exp v=0 c=2 a=0", valid, cnt, ack); end
      en = 1'b1;
   endtask

   task automatic test_wrap();
      logic [1:0] exp2 [5];
      exp2 = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
      do_reset();
      ready = 1'b1;
      for (int i = 0; i < 5; i++) begin
         din = 8'(i + 16); req = ~req;
         tickn(4);
         n_cmp++; if (cnt2 !== exp2[i] || cnt !== 16'(i + 1)) begin n_bad++; $display("FAIL wrap%0d: got c2=%0d c=%0d exp c2=%0d c=%0d", i, cnt2, cnt, exp2[i], i + 1); end
      end
   endtask

   task automatic test_reset_mid();
      do_reset();
      ready = 1'b1; din = 8'h12; req = ~req;
      tickn(4);
      n_cmp++; if (ack !== 1'b1 || cnt !== 16'd1) begin n_bad++; $display("FAIL mid_pre: got a=%b c=%0d exp a=1 c=1", ack, cnt); end
      ready = 1'b0; din = 8'h99; req = ~req;
      tickn(3);
      n_cmp++; if (valid !== 1'b1 || dout !== 8'h99) begin n_bad++; $display("FAIL mid_cap: got v=%b d=%h exp v=1 d=99", valid, dout); end
      rst = 1'b1; req = 1'b0;
      tick();
      n_cmp++; if (valid !== 1'b0 || dout !== 8'h00 || ack !== 1'b0 || cnt !== 16'd0 || err !== 1'b0) begin n_bad++; $display("FAIL mid_rst: got v=%b d=%h a=%b c=%0d e=%b exp all 0", valid, dout, ack, cnt, err); end
      rst = 1'b0;
      tickn(4);
      n_cmp++; if (valid !== 1'b0 || ack !== 1'b0) begin n_bad++; $display("FAIL mid_after: got v=%b a=%b exp v=0 a=0", valid, ack); end
   endtask

   initial begin
      test_reset();
      test_latency();
      test_hold_back_to_back();
      test_err();
      test_simultaneous();
      test_enable();
      test_wrap();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/ldl_cdc_hsk_rx_v1.md
# ldl_cdc_hsk_rx_v1

Destination-side controller for a multi-bit clock-domain crossing using a two-phase (toggle) request/acknowledge protocol. A single request bit is synchronised with the team's CDC synchroniser chain. The stable source data bus is captured on each detected request toggle and presented downstream on a valid/ready interface. The acknowledge toggle is returned to the source domain once the word has been consumed. The block sits in the receiving clock domain, paired with a source-side transmitter that holds data stable between its request toggle and the matching ack toggle.

## Interface
Parameters:
- WIDTH, 8, data bus width (≥1)
- LEVEL, 2, synchroniser depth for req_async (min. 2)
- CNT_W, 16, width of transfer counter

Ports:
- clk  in  1  destination-domain clock
- rst  in  1  synchronous, active-high reset
- en  in  1  enable; 0 freezes synchroniser and blocks new captures
- req_async  in  1  source request toggle (asynchronous to clk)
- din_async  in  WIDTH  source data, stable while a request is outstanding
- ack_out  out  1  acknowledge toggle returned to source domain (registered)
- dout  out  WIDTH  captured data
- dout_valid  out  1  dout holds an unconsumed word
- dout_ready  in  1  downstream accepts dout
- xfer_cnt  out  CNT_W  completed transfers, wraps modulo 2^CNT_W
- err  out  1  sticky protocol violation flag

## Operation
- req_async passes through a LEVEL-deep synchroniser (clock enable = en) to give req_sync.
- Register req_seen holds the last accepted request phase. A new request is defined as: new_req = (req_sync != req_seen).
- FSM states:
  - IDLE
    - en & new_req: dout <= din_async, req_seen <= req_sync, dout_valid <= 1, go to VALID.
    - Otherwise stay.
  - VALID
    - dout_ready: dout_valid <= 0, ack_out <= ~ack_out, xfer_cnt <= xfer_cnt+1, go to IDLE.
    - Otherwise hold dout and dout_valid unchanged.
- en = 0
  - Synchroniser holds and IDLE does not capture.
  - A VALID handshake still completes; the pending toggle is taken once en returns.
- err
  - Set when new_req is seen in VALID, i.e. the source toggled again before receiving ack.
  - The offending toggle is not captured.
  - Stays 1 until rst.
- dout never changes while dout_valid = 1.
- din_async is sampled without synchronisation. Correctness relies on the source protocol: data stable from its req toggle until it observes ack. Constrain the din_async paths as max-delay/false-path.

## Timing
- Reset values: ack_out 0, dout 0, dout_valid 0, xfer_cnt 0, err 0, req_seen 0, synchroniser 0, state IDLE. The source must also reset its req to 0.
- Reset mid-transfer drops any captured or pending word. No ack toggle is issued.
- Request latency, with en = 1 and req_async toggling before clk edge k:
  - req_sync changes after edge k+LEVEL-1.
  - dout_valid = 1 after edge k+LEVEL.
- Handshake: with dout_valid & dout_ready at edge m, after m: dout_valid = 0, ack_out toggled, xfer_cnt incremented.
- Minimum spacing between dout_valid assertions is 2 cycles (IDLE then VALID). True throughput is bounded by the source round trip.
- If dout_ready is already high when dout_valid rises, the word is consumed on the next edge (valid high 1 cycle).
- A simultaneous req toggle and dout_ready in VALID: the handshake completes and err sets.
- xfer_cnt wraps from 2^CNT_W-1 to 0 with no flag.

## Structure
- Package ldl_cdc_pkg: state typedef (enum logic {CDC_IDLE, CDC_VALID}), and the LEVEL minimum constant (CDC_LEVEL_MIN = 2) checked by an elaboration assertion.
- One sub-module: LDL_cdc_buff_v1 (WIDTH=1, LEVEL) for req_async; en drives its enable.
- Remaining logic (capture register, FSM, ack toggle, counter, err) lives in one always_ff block plus next-state logic, with no further hierarchy.

## Test plan
- Reset with req_async = 1 asserted throughout. After release, first edge: all outputs 0, and new_req flagged only after LEVEL cycles. Captures once, dout = din_async.
- LEVEL = 2, dout_ready = 1: toggle req with din = 0xA5. dout_valid rises exactly 2 edges later for 1 cycle, dout = 0xA5, ack_out toggles, xfer_cnt = 1.
- dout_ready = 0 for 10 cycles after capture. dout = 0x3C stays held and ack_out does not toggle. Raise ready → one handshake, then 4 back-to-back transfers with alternating data; xfer_cnt = 5, err = 0.
- Second req toggle before ack while VALID → err = 1 and stays after the handshake. The captured word is unchanged and no second capture occurs.
- en = 0 while req toggles: no capture. After en = 1, capture occurs LEVEL+1 edges later (chain resumes).
- CNT_W = 2, 5 transfers → xfer_cnt sequence 1, 2, 3, 0, 1. Reset asserted while VALID → outputs return to 0 and ack_out does not toggle.
